// File: rtl/alu_muldiv.sv
// Handshaked EX-stage ALU with registered result and iterative
// shift-add multiply / restoring divide taking WIDTH cycles.
module alu_muldiv #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             Flush,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [WIDTH-1:0] Source1,
   input  logic [WIDTH-1:0] Source2,
   input  logic [3:0]       ALU_Op,
   input  logic [2:0]       Br_Op,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             IsBranch,
   output logic             Busy
);
   localparam int CW = SHW + 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             isbr_q, isbr_d;
   logic             mul_q, mul_d, rem_q, rem_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d;
   logic             div0_q, div0_d;

   logic             accept, is_multi, is_mul, is_rem, is_sgn;
   logic             lt_s, lt_u, br_res;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sc_res, mag1, mag2;
   logic [WIDTH-1:0] acc_it, a_it, b_it, fin;
   logic [WIDTH:0]   rem_sh, diff;

   assign In_ready  = !Flush && ((state_q == S_IDLE) ||
                      (state_q == S_DONE && Out_ready));
   assign accept    = In_valid && In_ready;
   assign Out_valid = out_valid_q;
   assign Result    = result_q;
   assign IsBranch  = isbr_q;
   assign Busy      = busy_q;

   assign lt_s  = $signed(Source1) < $signed(Source2);
   assign lt_u  = Source1 < Source2;
   assign shamt = Source2[SHW-1:0];

   always_comb begin
      sc_res   = '0;
      is_multi = 1'b0;
      is_mul   = 1'b0;
      is_rem   = 1'b0;
      is_sgn   = 1'b0;
      case (ALU_Op)
         4'b0000: sc_res = Source1 & Source2;
         4'b0001: sc_res = Source1 | Source2;
         4'b1010: sc_res = Source1 ^ Source2;
         4'b0010: sc_res = Source1 + Source2;
         4'b0110: sc_res = Source1 - Source2;
         4'b0111: sc_res = {{(WIDTH-1){1'b0}}, lt_s};
         4'b1001: sc_res = {{(WIDTH-1){1'b0}}, lt_u};
         4'b1000: sc_res = Source1 << shamt;
         4'b1011: sc_res = Source1 >> shamt;
         4'b1100: sc_res = $signed(Source1) >>> shamt;
         4'b0011: begin is_multi = 1'b1; is_mul = 1'b1; end
         4'b0100: is_multi = 1'b1;
         4'b0101: begin is_multi = 1'b1; is_rem = 1'b1; end
         4'b1101: begin is_multi = 1'b1; is_sgn = 1'b1; end
         4'b1110: begin
            is_multi = 1'b1;
            is_rem   = 1'b1;
            is_sgn   = 1'b1;
         end
         default: sc_res = '0;
      endcase
   end

   always_comb begin
      case (Br_Op)
         3'b001:  br_res = Source1 == Source2;
         3'b010:  br_res = Source1 != Source2;
         3'b011:  br_res = lt_s;
         3'b100:  br_res = !lt_s;
         3'b101:  br_res = lt_u;
         3'b110:  br_res = !lt_u;
         default: br_res = 1'b0;
      endcase
   end

   // Magnitudes for signed divide; most-negative maps to 2^(W-1) unsigned.
   assign mag1 = (is_sgn && Source1[WIDTH-1]) ? -Source1 : Source1;
   assign mag2 = (is_sgn && Source2[WIDTH-1]) ? -Source2 : Source2;

   assign rem_sh = {acc_q, a_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, b_q};

   always_comb begin
      if (mul_q) begin
         acc_it = acc_q + (b_q[0] ? a_q : '0);
         a_it   = a_q << 1;
         b_it   = b_q >> 1;
      end else if (!diff[WIDTH]) begin
         acc_it = diff[WIDTH-1:0];
         a_it   = {a_q[WIDTH-2:0], 1'b1};
         b_it   = b_q;
      end else begin
         acc_it = rem_sh[WIDTH-1:0];
         a_it   = {a_q[WIDTH-2:0], 1'b0};
         b_it   = b_q;
      end
   end

   always_comb begin
      if (mul_q)       fin = acc_it;
      else if (rem_q)  fin = rneg_q ? -acc_it : acc_it;
      else if (div0_q) fin = '1;
      else             fin = qneg_q ? -a_it : a_it;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      isbr_d      = isbr_q;
      mul_d       = mul_q;
      rem_d       = rem_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      div0_d      = div0_q;
      if (Flush) begin
         state_d     = S_IDLE;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         busy_d      = 1'b0;
      end else if (accept) begin
         if (is_multi) begin
            state_d     = S_BUSY;
            cnt_d       = CW'(WIDTH);
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
            isbr_d      = 1'b0;
            acc_d       = '0;
            a_d         = is_mul ? Source1 : mag1;
            b_d         = is_mul ? Source2 : mag2;
            mul_d       = is_mul;
            rem_d       = is_rem;
            qneg_d      = is_sgn && (Source1[WIDTH-1] ^ Source2[WIDTH-1]);
            rneg_d      = is_sgn && Source1[WIDTH-1];
            div0_d      = Source2 == '0;
         end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = sc_res;
            isbr_d      = br_res;
         end
      end else begin
         case (state_q)
            S_DONE: begin
               if (Out_ready) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
               end
            end
            S_BUSY: begin
               acc_d = acc_it;
               a_d   = a_it;
               b_d   = b_it;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d     = S_DONE;
                  busy_d      = 1'b0;
                  out_valid_d = 1'b1;
                  result_d    = fin;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         isbr_q      <= 1'b0;
         mul_q       <= 1'b0;
         rem_q       <= 1'b0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         div0_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         isbr_q      <= isbr_d;
         mul_q       <= mul_d;
         rem_q       <= rem_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         div0_q      <= div0_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32: vector table plus
// handshake, backpressure, flush and reset sequences.
module tb_alu_muldiv;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        Flush = 1'b0;
   logic        In_valid = 1'b0;
   logic        In_ready;
   logic [31:0] Source1 = '0;
   logic [31:0] Source2 = '0;
   logic [3:0]  ALU_Op = '0;
   logic [2:0]  Br_Op = '0;
   logic        Out_valid;
   logic        Out_ready = 1'b0;
   logic [31:0] Result;
   logic        IsBranch;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   alu_muldiv #(.WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .Flush(Flush),
      .In_valid(In_valid), .In_ready(In_ready),
      .Source1(Source1), .Source2(Source2),
      .ALU_Op(ALU_Op), .Br_Op(Br_Op),
      .Out_valid(Out_valid), .Out_ready(Out_ready),
      .Result(Result), .IsBranch(IsBranch), .Busy(Busy)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [2:0]  br;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        isb;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic [3:0] op,
                      input logic [2:0] br, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res,
                      input logic isb, input int lat);
      vec_t v;
      v.name = nm; v.op = op; v.br = br; v.a = a; v.b = b;
      v.res = res; v.isb = isb; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [3:0] op, input logic [2:0] br,
                        input logic [31:0] a, input logic [31:0] b);
      In_valid = 1'b1;
      ALU_Op = op; Br_Op = br; Source1 = a; Source2 = b;
   endtask

   task automatic run_vec(input vec_t v);
      int cyc;
      int bcnt;
      @(negedge clk_i);
      Out_ready = 1'b0;
      chk({v.name, " in_ready"}, 32'(In_ready), 32'd1);
      drive(v.op, v.br, v.a, v.b);
      @(posedge clk_i); #1;
      In_valid = 1'b0;
      Source1 = 32'hDEAD_BEEF; Source2 = 32'h1234_5678;
      cyc = 1;
      bcnt = Busy ? 1 : 0;
      while (!Out_valid && cyc < 100) begin
         @(posedge clk_i); #1;
         cyc++;
         if (Busy) bcnt++;
      end
      chk({v.name, " latency"}, 32'(cyc), 32'(v.lat));
      chk({v.name, " busy_cycles"}, 32'(bcnt), (v.lat > 1) ? 32'd32 : 32'd0);
      chk({v.name, " result"}, Result, v.res);
      chk({v.name, " isbranch"}, 32'(IsBranch), 32'(v.isb));
      @(negedge clk_i);
      Out_ready = 1'b1;
      @(posedge clk_i); #1;
      Out_ready = 1'b0;
      chk({v.name, " drained"}, 32'(Out_valid), 32'd0);
   endtask

   task automatic watch_no_valid(input string nm, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i); #1;
         if (Out_valid) seen++;
      end
      chk(nm, 32'(seen), 32'd0);
   endtask

   initial begin
      add("add",    4'b0010, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'd4, 1'b0, 1);
      add("sra",    4'b1100, 3'b000, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
      add("sub",    4'b0110, 3'b000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
      add("and",    4'b0000, 3'b000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1);
      add("or",     4'b0001, 3'b000, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1);
      add("xor",    4'b1010, 3'b000, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 1);
      add("slt",    4'b0111, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
      add("sltu",   4'b1001, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
      add("sll",    4'b1000, 3'b000, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1);
      add("sll_m",  4'b1000, 3'b000, 32'd1, 32'd33, 32'd2, 1'b0, 1);
      add("srl",    4'b1011, 3'b000, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
      add("op1111", 4'b1111, 3'b001, 32'd3, 32'd3, 32'd0, 1'b1, 1);
      add("br_lt",  4'b0010, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
      add("br_ltu", 4'b0010, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
      add("br_ne",  4'b0010, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
      add("br_eq",  4'b0010, 3'b001, 32'd5, 32'd5, 32'd10, 1'b1, 1);
      add("br_ge",  4'b0010, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
      add("br_geu", 4'b0010, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
      add("br_111", 4'b0010, 3'b111, 32'd5, 32'd5, 32'd10, 1'b0, 1);
      add("mul",    4'b0011, 3'b000, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
      add("mul_br", 4'b0011, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33);
      add("mul_neg",4'b0011, 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 33);
      add("div",    4'b1101, 3'b000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
      add("rem",    4'b1110, 3'b000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
      add("divu0",  4'b0100, 3'b000, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
      add("remu0",  4'b0101, 3'b000, 32'd7, 32'd0, 32'd7, 1'b0, 33);
      add("div_ov", 4'b1101, 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
      add("rem_ov", 4'b1110, 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
      add("div_z",  4'b1101, 3'b000, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
      add("rem_z",  4'b1110, 3'b000, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 33);
      add("divu",   4'b0100, 3'b000, 32'd100, 32'd7, 32'd14, 1'b0, 33);
      add("remu",   4'b0101, 3'b000, 32'd100, 32'd7, 32'd2, 1'b0, 33);
      add("div_pn", 4'b1101, 3'b000, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 1'b0, 33);
      add("rem_pn", 4'b1110, 3'b000, 32'd20, 32'hFFFF_FFFA, 32'd2, 1'b0, 33);

      #2;
      chk("rst out_valid", 32'(Out_valid), 32'd0);
      chk("rst result", Result, 32'd0);
      chk("rst isbranch", 32'(IsBranch), 32'd0);
      chk("rst busy", 32'(Busy), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("rst in_ready", 32'(In_ready), 32'd1);

      // back-to-back single-cycle ops
      @(negedge clk_i);
      Out_ready = 1'b1;
      drive(4'b0010, 3'b000, 32'd7, 32'hFFFF_FFFD);
      @(posedge clk_i); #1;
      chk("b2b add valid", 32'(Out_valid), 32'd1);
      chk("b2b add result", Result, 32'd4);
      chk("b2b in_ready", 32'(In_ready), 32'd1);
      @(negedge clk_i);
      drive(4'b1100, 3'b000, 32'h8000_0000, 32'd4);
      @(posedge clk_i); #1;
      chk("b2b sra valid", 32'(Out_valid), 32'd1);
      chk("b2b sra result", Result, 32'hF800_0000);
      @(negedge clk_i);
      In_valid = 1'b0;
      @(posedge clk_i); #1;
      chk("b2b idle", 32'(Out_valid), 32'd0);
      Out_ready = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // backpressure
      @(negedge clk_i);
      drive(4'b0010, 3'b000, 32'd1, 32'd2);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      drive(4'b0110, 3'b000, 32'd10, 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #1;
         chk("bp result", Result, 32'd3);
         chk("bp in_ready", 32'(In_ready), 32'd0);
         chk("bp valid", 32'(Out_valid), 32'd1);
      end
      @(negedge clk_i);
      Out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 32'(In_ready), 32'd1);
      @(posedge clk_i); #1;
      chk("bp second result", Result, 32'd7);
      chk("bp second valid", 32'(Out_valid), 32'd1);
      @(negedge clk_i);
      In_valid = 1'b0;
      @(posedge clk_i); #1;
      chk("bp idle", 32'(Out_valid), 32'd0);
      Out_ready = 1'b0;

      // flush at cycle 10 of a DIV
      @(negedge clk_i);
      drive(4'b1101, 3'b000, 32'd100, 32'd3);
      @(posedge clk_i); #1;
      In_valid = 1'b0;
      repeat (9) @(posedge clk_i);
      @(negedge clk_i);
      chk("fl busy before", 32'(Busy), 32'd1);
      Flush = 1'b1;
      #1;
      chk("fl in_ready", 32'(In_ready), 32'd0);
      @(posedge clk_i); #1;
      chk("fl busy after", 32'(Busy), 32'd0);
      chk("fl valid after", 32'(Out_valid), 32'd0);
      @(negedge clk_i);
      Flush = 1'b0;
      Out_ready = 1'b1;
      watch_no_valid("fl no output", 40);
      chk("fl idle in_ready", 32'(In_ready), 32'd1);
      Out_ready = 1'b0;

      // flush in IDLE drops the accept
      @(negedge clk_i);
      Flush = 1'b1;
      drive(4'b0010, 3'b000, 32'd1, 32'd1);
      @(posedge clk_i); #1;
      chk("fl idle drop", 32'(Out_valid), 32'd0);
      @(negedge clk_i);
      Flush = 1'b0;
      In_valid = 1'b0;
      watch_no_valid("fl idle no output", 3);

      // async reset mid-BUSY
      @(negedge clk_i);
      drive(4'b1101, 3'b011, 32'hFFFF_FFF9, 32'd2);
      @(posedge clk_i); #1;
      In_valid = 1'b0;
      repeat (5) @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      chk("ar busy", 32'(Busy), 32'd0);
      chk("ar valid", 32'(Out_valid), 32'd0);
      chk("ar result", Result, 32'd0);
      chk("ar isbranch", 32'(IsBranch), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("ar in_ready", 32'(In_ready), 32'd1);
      watch_no_valid("ar no output", 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
